mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle main controller for the RV32I core. It replaces the combinational single-cycle decoder when the datapath is re-pipelined around a shared ALU and a unified instruction/data memory.
- A Moore FSM sequences fetch, decode, execute, memory and writeback. It drives the PC, instruction-register, memory and register-file write enables and all datapath mux selects.
- It also counts retired instructions and halts on an illegal encoding.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- run  input  1  level; 1 permits leaving FETCH; 0 parks the FSM in FETCH
- Op  input  7  instruction opcode (IR[6:0])
- F3  input  3  funct3 (IR[14:12])
- F7_5  input  1  funct7 bit 5 (IR[30])
- Zero  input  1  ALU zero flag
- pc_we  output  1  PC write enable
- ir_we  output  1  instruction/old-PC register write enable
- adr_src  output  1  memory address select: 0 = PC, 1 = result bus
- mem_we  output  1  data memory write enable
- reg_we  output  1  register file write enable
- alu_src_a  output  2  ALU operand A: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  output  2  ALU operand B: 00 = rs2, 01 = imm, 10 = const 4
- alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU
- imm_op  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_src  output  2  00 = ALU-out register, 01 = memory-data register, 10 = ALU direct, 11 = imm
- instr_done  output  1  one-cycle pulse in the last cycle of every instruction
- halted  output  1  sticky illegal-instruction flag
- ret_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous):
  - state = FETCH, ret_cnt = 0, halted = 0.
  - All enables are 0 and all selects are 0 while reset is held.
  - Reset asserted mid-instruction aborts it; no partial write occurs after reset is asserted.
- Default output values in every state: all enables 0, selects 00, alu_op = ADD.
- imm_op is decoded combinationally from Op in every state:
  - 0000011/0010011/1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - 0110111 → U
  - anything else → I
- States and outputs:
  - FETCH, run=1: adr_src=0, ir_we=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10, pc_we=1 → DECODE.
  - FETCH, run=0: no enables asserted; stay in FETCH.
  - DECODE: alu_src_a=01, alu_src_b=01, ADD (precomputes the branch/JAL target into ALU-out). Next state by Op:
    - LW/SW → MEM_ADR
    - R-type (0110011) → EXEC_R
    - I-ALU (0010011) → EXEC_I
    - branch → BRANCH
    - JAL → JAL
    - JALR → JALR1
    - LUI → LUI
    - other → HALT
  - MEM_ADR: alu_src_a=10, alu_src_b=01, ADD → MEM_RD if Op=LW, else MEM_WR.
  - MEM_RD: result_src=00, adr_src=1 → MEM_WB.
  - MEM_WB: result_src=01, reg_we=1, instr_done → FETCH.
  - MEM_WR: result_src=00, adr_src=1, mem_we=1, instr_done → FETCH.
  - EXEC_R: alu_src_a=10, alu_src_b=00, alu_op from F3 (table below) → ALU_WB.
  - EXEC_I: alu_src_a=10, alu_src_b=01, alu_op from F3 with F7_5 ignored → ALU_WB.
  - ALU_WB: result_src=00, reg_we=1, instr_done → FETCH.
  - BRANCH: alu_src_a=10, alu_src_b=00, result_src=00, instr_done → FETCH. Per F3:
    - 000 beq: SUB, pc_we = Zero
    - 001 bne: SUB, pc_we = !Zero
    - 100 blt: SLT, pc_we = !Zero
    - 101 bge: SLT, pc_we = Zero
    - other F3 → HALT instead, with no pc_we and no instr_done.
    - pc_we in this state is the only Mealy output.
  - JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_we=1 → ALU_WB (rd = old PC + 4).
  - JALR1: alu_src_a=10, alu_src_b=01, ADD → JALR2.
  - JALR2: same ALU setting as JAL, result_src=00, pc_we=1 → ALU_WB.
  - LUI: result_src=11, reg_we=1, instr_done → FETCH.
  - HALT: all enables 0, halted=1; absorbing until reset.
- F3 → alu_op:
  - 000: ADD; SUB only when R-type and F7_5=1
  - 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU
  - 001/101 (shifts) → HALT
- Latencies in cycles, FETCH included: LW 5, SW 4, R 4, I 4, branch 3, JAL 4, JALR 5, LUI 3.
- ret_cnt increments by 1 on every instr_done cycle and wraps modulo 2^CNT_W.
- run is sampled only in FETCH; deasserting it mid-instruction does not stall that instruction.

Test Plan:
- Reset release with run=1 and Op=0110011, F3=000, F7_5=1 → states FETCH, DECODE, EXEC_R (alu_op=001), ALU_WB (reg_we=1, instr_done=1); ret_cnt=1 after 4 cycles.
- LW (Op=0000011) → 5 cycles; MEM_RD has adr_src=1; MEM_WB has result_src=01 and reg_we=1. SW (0100011) → mem_we=1 only in cycle 4.
- BEQ with Zero=1 → pc_we=1 in cycle 3. BLT with Zero=1 → pc_we=0 in cycle 3. F3=010 on a branch → halted=1 and ret_cnt unchanged.
- run=0 for 10 cycles → FETCH held with pc_we=ir_we=0. run=1 → fetch occurs on the next edge.
- Assert rst during MEM_WR (mem_we=1) → mem_we drops asynchronously, state=FETCH, ret_cnt=0.
- Preload ret_cnt to all-ones with CNT_W=4, then retire one LUI → ret_cnt=0. Op=1111111 → HALT, held across 20 cycles until reset.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I main controller: Moore FSM sequencing fetch through
// writeback, with a retired-instruction counter and a sticky halt on illegal ops.
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       Op,
  input  logic [2:0]       F3,
  input  logic             F7_5,
  input  logic             Zero,
  output logic             pc_we,
  output logic             ir_we,
  output logic             adr_src,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [2:0]       imm_op,
  output logic [1:0]       result_src,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_EXEC_R, S_EXEC_I,
    S_ALU_WB, S_BRANCH, S_JAL, S_JALR1,
    S_JALR2, S_LUI, S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_pc_we;
  logic       w_ir_we;
  logic       w_adr;
  logic       w_mem_we;
  logic       w_reg_we;
  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [2:0] w_alu;
  logic [2:0] w_imm;
  logic [1:0] w_res;
  logic       w_done;
  logic [2:0] w_f3_alu;
  logic       w_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_imm = 3'b000;
    unique case (1'b1)
      (Op == OP_SW):  w_imm = 3'b001;
      (Op == OP_B):   w_imm = 3'b010;
      (Op == OP_JAL): w_imm = 3'b011;
      (Op == OP_LUI): w_imm = 3'b100;
      default:        w_imm = 3'b000;
    endcase
  end

  always_comb begin
    w_f3_alu = ALU_ADD;
    w_shift  = 1'b0;
    case (F3)
      3'b000: w_f3_alu = (r_state == S_EXEC_R && F7_5) ? ALU_SUB : ALU_ADD;
      3'b111: w_f3_alu = ALU_AND;
      3'b110: w_f3_alu = ALU_OR;
      3'b100: w_f3_alu = ALU_XOR;
      3'b010: w_f3_alu = ALU_SLT;
      3'b011: w_f3_alu = ALU_SLTU;
      default: w_shift = 1'b1;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_pc_we  = 1'b0;
    w_ir_we  = 1'b0;
    w_adr    = 1'b0;
    w_mem_we = 1'b0;
    w_reg_we = 1'b0;
    w_a      = 2'b00;
    w_b      = 2'b00;
    w_alu    = ALU_ADD;
    w_res    = 2'b00;
    w_done   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (run) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_b     = 2'b10;
          w_res   = 2'b10;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU-out latches PC_old + imm as the branch/JAL target
        w_a = 2'b01;
        w_b = 2'b01;
        case (Op)
          OP_LW, OP_SW: w_next = S_MEM_ADR;
          OP_R:         w_next = S_EXEC_R;
          OP_I:         w_next = S_EXEC_I;
          OP_B:         w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR1;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEM_ADR: begin
        w_a    = 2'b10;
        w_b    = 2'b01;
        w_next = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_adr  = 1'b1;
        w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_res    = 2'b01;
        w_reg_we = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WR: begin
        w_adr    = 1'b1;
        w_mem_we = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        w_a    = 2'b10;
        w_b    = (r_state == S_EXEC_I) ? 2'b01 : 2'b00;
        w_alu  = w_f3_alu;
        w_next = w_shift ? S_HALT : S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_we = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        w_a    = 2'b10;
        w_next = S_HALT;
        case (F3)
          3'b000: begin w_alu = ALU_SUB; w_pc_we = Zero;  end
          3'b001: begin w_alu = ALU_SUB; w_pc_we = !Zero; end
          3'b100: begin w_alu = ALU_SLT; w_pc_we = !Zero; end
          3'b101: begin w_alu = ALU_SLT; w_pc_we = Zero;  end
          default: w_alu = ALU_ADD;
        endcase
        if (F3 == 3'b000 || F3 == 3'b001 ||
            F3 == 3'b100 || F3 == 3'b101) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_JAL, S_JALR2: begin
        w_a     = 2'b01;
        w_b     = 2'b10;
        w_pc_we = 1'b1;
        w_next  = S_ALU_WB;
      end
      S_JALR1: begin
        w_a    = 2'b10;
        w_b    = 2'b01;
        w_next = S_JALR2;
      end
      S_LUI: begin
        w_res    = 2'b11;
        w_reg_we = 1'b1;
        w_done   = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  // Gate with reset so nothing leaks out while it is held
  assign pc_we      = rst & w_pc_we;
  assign ir_we      = rst & w_ir_we;
  assign adr_src    = rst & w_adr;
  assign mem_we     = rst & w_mem_we;
  assign reg_we     = rst & w_reg_we;
  assign alu_src_a  = rst ? w_a   : 2'b00;
  assign alu_src_b  = rst ? w_b   : 2'b00;
  assign alu_op     = rst ? w_alu : 3'b000;
  assign imm_op     = rst ? w_imm : 3'b000;
  assign result_src = rst ? w_res : 2'b00;
  assign instr_done = rst & w_done;
  assign halted     = rst & (r_state == S_HALT);
  assign ret_cnt    = r_cnt;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-cycle expected outputs queued per instruction,
// plus reset, park, halt and counter-wrap sequences.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [6:0] Op;
  logic [2:0] F3;
  logic       F7_5;
  logic       Zero;

  logic        pc_we, ir_we, adr_src, mem_we, reg_we;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_op, imm_op;
  logic        instr_done, halted;
  logic [31:0] ret_cnt;

  logic        d4_pc_we, d4_ir_we, d4_adr_src, d4_mem_we, d4_reg_we;
  logic [1:0]  d4_alu_src_a, d4_alu_src_b, d4_result_src;
  logic [2:0]  d4_alu_op, d4_imm_op;
  logic        d4_instr_done, d4_halted;
  logic [3:0]  d4_ret_cnt;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .run(run), .Op(Op), .F3(F3),
    .F7_5(F7_5), .Zero(Zero),
    .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src),
    .mem_we(mem_we), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_op(imm_op), .result_src(result_src),
    .instr_done(instr_done), .halted(halted), .ret_cnt(ret_cnt)
  );

  mc_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .Op(Op), .F3(F3),
    .F7_5(F7_5), .Zero(Zero),
    .pc_we(d4_pc_we), .ir_we(d4_ir_we), .adr_src(d4_adr_src),
    .mem_we(d4_mem_we), .reg_we(d4_reg_we),
    .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b),
    .alu_op(d4_alu_op), .imm_op(d4_imm_op), .result_src(d4_result_src),
    .instr_done(d4_instr_done), .halted(d4_halted), .ret_cnt(d4_ret_cnt)
  );

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       adr;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [2:0] imm;
    logic [1:0] res;
    logic       done;
    logic       halted;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
  } vec_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] RR = 7'b0110011, II = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111;

  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;
  out_t sb[$];
  vec_t vt[$];

  function automatic out_t dut_out();
    out_t o;
    o.pc_we = pc_we; o.ir_we = ir_we; o.adr = adr_src;
    o.mem_we = mem_we; o.reg_we = reg_we;
    o.a = alu_src_a; o.b = alu_src_b; o.alu = alu_op;
    o.imm = imm_op; o.res = result_src;
    o.done = instr_done; o.halted = halted;
    return o;
  endfunction

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    logic [31:0] e32;
    logic [3:0]  e4;
    e32 = exp_cnt;
    e4  = e32[3:0];
    chk_int({nm, "_cnt32"}, int'(ret_cnt), int'(e32));
    chk_int({nm, "_cnt4"}, int'(d4_ret_cnt), int'(e4));
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      SW:      return 3'd1;
      BR:      return 3'd2;
      JAL:     return 3'd3;
      LUI:     return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] aluf(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b010:  return 3'd5;
      3'b011:  return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  task automatic build(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z);
    out_t b, o, wb, jl;
    b = '0;
    b.imm = imm_of(op);
    wb = b; wb.reg_we = 1; wb.done = 1;
    jl = b; jl.a = 2'b01; jl.b = 2'b10; jl.pc_we = 1;
    o = b; o.ir_we = 1; o.pc_we = 1; o.b = 2'b10; o.res = 2'b10;
    sb.push_back(o);
    o = b; o.a = 2'b01; o.b = 2'b01;
    sb.push_back(o);
    case (op)
      LW, SW: begin
        o = b; o.a = 2'b10; o.b = 2'b01;
        sb.push_back(o);
        if (op == LW) begin
          o = b; o.adr = 1;
          sb.push_back(o);
          o = wb; o.res = 2'b01;
          sb.push_back(o);
        end else begin
          o = b; o.adr = 1; o.mem_we = 1; o.done = 1;
          sb.push_back(o);
        end
      end
      RR, II: begin
        o = b; o.a = 2'b10; o.b = (op == II) ? 2'b01 : 2'b00;
        o.alu = aluf(f3, (op == RR) && f7);
        sb.push_back(o);
        sb.push_back(wb);
      end
      BR: begin
        o = b; o.a = 2'b10; o.done = 1;
        o.alu = f3[2] ? 3'd5 : 3'd1;
        o.pc_we = (f3 == 3'b000 || f3 == 3'b101) ? z : !z;
        sb.push_back(o);
      end
      JAL: begin
        sb.push_back(jl);
        sb.push_back(wb);
      end
      JALR: begin
        o = b; o.a = 2'b10; o.b = 2'b01;
        sb.push_back(o);
        sb.push_back(jl);
        sb.push_back(wb);
      end
      LUI: begin
        o = wb; o.res = 2'b11;
        sb.push_back(o);
      end
      default: ;
    endcase
  endtask

  // Entry: just after a rising edge with the DUT in FETCH
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z,
                           input int lat, input bit drop_run);
    out_t e;
    int   n;
    int   done_at;
    Op = op; F3 = f3; F7_5 = f7; Zero = z;
    build(op, f3, f7, z);
    n = sb.size();
    done_at = 0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk_out($sformatf("op%b_f3%b_c%0d", op, f3, c), dut_out(), e);
      chk_cnt($sformatf("op%b_c%0d", op, c));
      if (instr_done === 1'b1 && done_at == 0) done_at = c;
      if (e.done) exp_cnt++;
      @(posedge clk);
      #1;
      if (drop_run && c == 1) run = 0;
    end
    chk_int($sformatf("lat_op%b_f3%b", op, f3), done_at, lat);
    run = 1;
  endtask

  task automatic do_reset();
    out_t z;
    z = '0;
    @(negedge clk);
    rst = 0;
    #1;
    chk_out("reset_outs", dut_out(), z);
    exp_cnt = 0;
    chk_cnt("reset");
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic run_halt(input logic [6:0] op, input logic [2:0] f3,
                          input int hcyc, input int n);
    Op = op; F3 = f3; F7_5 = 0; Zero = 1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c > 1)
        chk_int($sformatf("halt_en_op%b_c%0d", op, c),
                int'({pc_we, ir_we, mem_we, reg_we, instr_done}), 0);
      chk_int($sformatf("halted_op%b_c%0d", op, c),
              int'(halted), (c >= hcyc) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    chk_cnt($sformatf("halt_op%b", op));
  endtask

  initial begin
    out_t e;
    out_t idle;
    rst = 0; run = 1;
    Op = RR; F3 = 3'b000; F7_5 = 1; Zero = 0;

    vt.push_back('{RR,   3'b000, 1'b1, 1'b0, 4});
    vt.push_back('{RR,   3'b000, 1'b0, 1'b0, 4});
    vt.push_back('{RR,   3'b111, 1'b0, 1'b1, 4});
    vt.push_back('{RR,   3'b110, 1'b1, 1'b0, 4});
    vt.push_back('{RR,   3'b010, 1'b0, 1'b0, 4});
    vt.push_back('{RR,   3'b011, 1'b0, 1'b0, 4});
    vt.push_back('{II,   3'b000, 1'b1, 1'b0, 4});
    vt.push_back('{II,   3'b100, 1'b0, 1'b0, 4});
    vt.push_back('{LW,   3'b010, 1'b0, 1'b0, 5});
    vt.push_back('{SW,   3'b010, 1'b0, 1'b0, 4});
    vt.push_back('{BR,   3'b000, 1'b0, 1'b1, 3});
    vt.push_back('{BR,   3'b000, 1'b0, 1'b0, 3});
    vt.push_back('{BR,   3'b001, 1'b0, 1'b0, 3});
    vt.push_back('{BR,   3'b001, 1'b0, 1'b1, 3});
    vt.push_back('{BR,   3'b100, 1'b0, 1'b1, 3});
    vt.push_back('{BR,   3'b100, 1'b0, 1'b0, 3});
    vt.push_back('{BR,   3'b101, 1'b0, 1'b1, 3});
    vt.push_back('{JAL,  3'b000, 1'b0, 1'b0, 4});
    vt.push_back('{JALR, 3'b000, 1'b0, 1'b0, 5});
    vt.push_back('{LUI,  3'b000, 1'b0, 1'b0, 3});

    repeat (2) @(negedge clk);
    chk_out("reset_hold", dut_out(), '0);
    chk_cnt("reset_hold");
    @(posedge clk);
    #1;
    rst = 1;

    foreach (vt[i])
      run_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, vt[i].lat, 1'b0);

    // Park in FETCH with run low
    run = 0;
    Op = LUI;
    idle = '0;
    idle.imm = 3'd4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_out($sformatf("park_c%0d", c), dut_out(), idle);
      @(posedge clk);
      #1;
    end
    run = 1;
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 3, 1'b0);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 5, 1'b1);

    // Reset asserted while SW is in its write cycle
    Op = SW; F3 = 3'b010; F7_5 = 0; Zero = 0;
    build(SW, 3'b010, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk_out($sformatf("swrst_c%0d", c), dut_out(), e);
      if (c < 4) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst = 0;
    #1;
    chk_int("rst_mem_we", int'(mem_we), 0);
    chk_out("rst_async_outs", dut_out(), '0);
    exp_cnt = 0;
    chk_cnt("rst_async");
    @(posedge clk);
    #1;
    rst = 1;
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 3, 1'b0);

    run_halt(BR, 3'b010, 4, 8);
    do_reset();
    run_halt(II, 3'b001, 4, 8);
    do_reset();
    run_halt(7'b1111111, 3'b000, 3, 22);
    do_reset();

    // Narrow counter wraps after 16 retirements
    for (int k = 0; k < 15; k++)
      run_instr(LUI, 3'b000, 1'b0, 1'b0, 3, 1'b0);
    chk_int("cnt4_allones", int'(d4_ret_cnt), 15);
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 3, 1'b0);
    chk_int("cnt4_wrap", int'(d4_ret_cnt), 0);
    chk_int("cnt32_nowrap", int'(ret_cnt), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
